// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file with two combinational read ports, one write port and a
// per-register busy (result pending) scoreboard.  After reset, or on request,
// the array and scoreboard are zeroed one entry per clock.  Accesses are
// accepted only while Ready is high.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG  1: register 0 reads 0, is never busy, ignores writes and marks
//
// Ports
//   CLK        clock, rising-edge
//   Reset      synchronous active-high reset, restarts the clear sequence
//   RegWre     write enable for WriteReg/WriteData (clears its busy bit)
//   WriteReg   write address
//   WriteData  write data
//   MarkWre    set busy[MarkReg]
//   MarkReg    register to mark busy
//   ClearReq   start a full sequential clear
//   rs, rt     read addresses
//   ReadData1  data for rs (combinational, bypasses a same-cycle write)
//   ReadData2  data for rt (combinational, bypasses a same-cycle write)
//   Busy1      busy bit for rs
//   Busy2      busy bit for rt
//   Ready      high while idle; all read outputs are forced to 0 otherwise
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              RegWre,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              MarkWre,
   input  logic [ADDR_W-1:0] MarkReg,
   input  logic              ClearReq,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic              Busy1,
   output logic              Busy2,
   output logic              Ready
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] ZERO_DAT = {DATA_W{1'b0}};

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;

   logic              ready_s;
   logic              wr_ok_s;
   logic              mk_ok_s;

   // Register 0 is hard-wired when ZERO_REG is set.
   function automatic logic is_protected(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == ZERO_IDX);
   endfunction

   assign ready_s = (state_q == ST_IDLE);
   // Accesses are qualified by Ready so anything arriving during a clear is dropped.
   assign wr_ok_s = ready_s && RegWre  && !is_protected(WriteReg);
   assign mk_ok_s = ready_s && MarkWre && !is_protected(MarkReg);
   assign Ready   = ready_s;

   // Next-state logic for the FSM, clear index, register array and scoreboard.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      regs_d  = regs_q;
      busy_d  = busy_q;
      case (state_q)
         ST_CLEAR: begin
            regs_d[idx_q] = ZERO_DAT;
            busy_d[idx_q] = 1'b0;
            idx_d         = idx_q + ONE_IDX;   // wraps to 0 after LAST_IDX
            if (idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (wr_ok_s) begin
               regs_d[WriteReg] = WriteData;
               busy_d[WriteReg] = 1'b0;
            end else begin
               regs_d = regs_q;
            end
            // Applied after the write so a same-cycle mark on the same register wins.
            if (mk_ok_s) begin
               busy_d[MarkReg] = 1'b1;
            end else begin
               busy_d[MarkReg] = busy_d[MarkReg];
            end
            if (ClearReq) begin
               state_d = ST_CLEAR;
               idx_d   = ZERO_IDX;
            end else begin
               state_d = ST_IDLE;
               idx_d   = idx_q;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = ZERO_IDX;
         end
      endcase
   end

   // State, index, array and scoreboard flops; Reset restarts the clear without touching the array.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= ST_CLEAR;
         idx_q   <= ZERO_IDX;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         regs_q  <= regs_d;
         busy_q  <= busy_d;
      end
   end

   // Read port 1: gated by Ready, hard zero for register 0, write bypass, else array.
   always_comb begin
      ReadData1 = ZERO_DAT;
      Busy1     = 1'b0;
      if (!ready_s || is_protected(rs)) begin
         ReadData1 = ZERO_DAT;
         Busy1     = 1'b0;
      end else if (wr_ok_s && (WriteReg == rs)) begin
         ReadData1 = WriteData;
         Busy1     = mk_ok_s && (MarkReg == rs);
      end else begin
         ReadData1 = regs_q[rs];
         Busy1     = busy_q[rs];
      end
   end

   // Read port 2: same behaviour as port 1 for the rt address.
   always_comb begin
      ReadData2 = ZERO_DAT;
      Busy2     = 1'b0;
      if (!ready_s || is_protected(rt)) begin
         ReadData2 = ZERO_DAT;
         Busy2     = 1'b0;
      end else if (wr_ok_s && (WriteReg == rt)) begin
         ReadData2 = WriteData;
         Busy2     = mk_ok_s && (MarkReg == rt);
      end else begin
         ReadData2 = regs_q[rt];
         Busy2     = busy_q[rt];
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        RegWre = 1'b0, MarkWre = 1'b0, ClearReq = 1'b0;
   logic [3:0]  WriteReg = 4'd0, MarkReg = 4'd0, rs = 4'd0, rt = 4'd0;
   logic [15:0] WriteData = 16'h0;

   // default-parameter instance outputs
   logic [15:0] rd1_a, rd2_a;
   logic        b1_a, b2_a, rdy_a;
   // ZERO_REG = 0 instance outputs (same inputs)
   logic [15:0] rd1_b, rd2_b;
   logic        b1_b, b2_b, rdy_b;

   // wide instance
   logic        Reset2 = 1'b1;
   logic        RegWre2 = 1'b0, MarkWre2 = 1'b0, ClearReq2 = 1'b0;
   logic [4:0]  WriteReg2 = 5'd0, MarkReg2 = 5'd0, rs2 = 5'd0, rt2 = 5'd0;
   logic [31:0] WriteData2 = 32'h0;
   logic [31:0] rd1_c, rd2_c;
   logic        b1_c, b2_c, rdy_c;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_scoreboard dut_a (
      .CLK(clk), .Reset(Reset), .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .MarkWre(MarkWre), .MarkReg(MarkReg), .ClearReq(ClearReq), .rs(rs), .rt(rt),
      .ReadData1(rd1_a), .ReadData2(rd2_a), .Busy1(b1_a), .Busy2(b2_a), .Ready(rdy_a));

   regfile_scoreboard #(.ZERO_REG(0)) dut_b (
      .CLK(clk), .Reset(Reset), .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
      .MarkWre(MarkWre), .MarkReg(MarkReg), .ClearReq(ClearReq), .rs(rs), .rt(rt),
      .ReadData1(rd1_b), .ReadData2(rd2_b), .Busy1(b1_b), .Busy2(b2_b), .Ready(rdy_b));

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut_c (
      .CLK(clk), .Reset(Reset2), .RegWre(RegWre2), .WriteReg(WriteReg2), .WriteData(WriteData2),
      .MarkWre(MarkWre2), .MarkReg(MarkReg2), .ClearReq(ClearReq2), .rs(rs2), .rt(rt2),
      .ReadData1(rd1_c), .ReadData2(rd2_c), .Busy1(b1_c), .Busy2(b2_c), .Ready(rdy_c));

   // advance one rising edge, then settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegWre = 1'b0; MarkWre = 1'b0; ClearReq = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1; rs = 4'd5; rt = 4'd9;
      tick(); tick();
      n_tests++; if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_held: got %b want 0", rdy_a); end
      Reset = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         n_tests++; if (rdy_a !== (e == 16)) begin n_fail++; $display("FAIL reset_ready edge %0d: got %b want %b", e, rdy_a, (e == 16)); end
         if (e < 16) begin
            n_tests++; if ({rd1_a, b1_a} !== 17'h0) begin n_fail++; $display("FAIL reset_gated_read edge %0d: got %h/%b want 0/0", e, rd1_a, b1_a); end
         end
      end
      n_tests++; if (rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready_zr0: got %b want 1", rdy_b); end
      for (int a = 0; a < 16; a++) begin
         rs = 4'(a); rt = 4'(a); #1;
         n_tests++;
         if (rd1_a !== 16'h0 || rd2_a !== 16'h0 || b1_a !== 1'b0 || b2_a !== 1'b0) begin
            n_fail++; $display("FAIL reset_zero R%0d: got %h %h %b %b want 0 0 0 0", a, rd1_a, rd2_a, b1_a, b2_a);
         end
      end
   endtask

   task automatic test_bypass();
      RegWre = 1'b1; WriteReg = 4'd5; WriteData = 16'h1234; rs = 4'd5; rt = 4'd6; #1;
      n_tests++; if (rd1_a !== 16'h1234 || b1_a !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got %h/%b want 1234/0", rd1_a, b1_a); end
      n_tests++; if (rd2_a !== 16'h0) begin n_fail++; $display("FAIL bypass_other_port: got %h want 0", rd2_a); end
      tick();
      idle_inputs(); #1;
      n_tests++; if (rd1_a !== 16'h1234) begin n_fail++; $display("FAIL bypass_from_array: got %h want 1234", rd1_a); end
      rt = 4'd5; #1;
      n_tests++; if (rd2_a !== rd1_a || rd2_a !== 16'h1234) begin n_fail++; $display("FAIL rs_eq_rt: got %h/%h want 1234/1234", rd1_a, rd2_a); end
   endtask

   task automatic test_scoreboard();
      MarkWre = 1'b1; MarkReg = 4'd3; rt = 4'd3; #1;
      n_tests++; if (b2_a !== 1'b0) begin n_fail++; $display("FAIL mark_not_yet_visible: got %b want 0", b2_a); end
      tick();
      idle_inputs(); #1;
      n_tests++; if (b2_a !== 1'b1) begin n_fail++; $display("FAIL mark_busy: got %b want 1", b2_a); end
      RegWre = 1'b1; WriteReg = 4'd3; WriteData = 16'hBEEF; #1;
      n_tests++; if (b2_a !== 1'b0 || rd2_a !== 16'hBEEF) begin n_fail++; $display("FAIL write_clears_bypass: got %h/%b want beef/0", rd2_a, b2_a); end
      tick();
      idle_inputs(); #1;
      n_tests++; if (b2_a !== 1'b0 || rd2_a !== 16'hBEEF) begin n_fail++; $display("FAIL write_clears_stored: got %h/%b want beef/0", rd2_a, b2_a); end
      RegWre = 1'b1; WriteReg = 4'd7; WriteData = 16'h00A5; MarkWre = 1'b1; MarkReg = 4'd7; rs = 4'd7; #1;
      n_tests++; if (b1_a !== 1'b1 || rd1_a !== 16'h00A5) begin n_fail++; $display("FAIL mark_wins_bypass: got %h/%b want 00a5/1", rd1_a, b1_a); end
      tick();
      idle_inputs(); #1;
      n_tests++; if (b1_a !== 1'b1 || rd1_a !== 16'h00A5) begin n_fail++; $display("FAIL mark_wins_stored: got %h/%b want 00a5/1", rd1_a, b1_a); end
   endtask

   task automatic test_zero_reg();
      RegWre = 1'b1; WriteReg = 4'd0; WriteData = 16'hFFFF; MarkWre = 1'b1; MarkReg = 4'd0; rs = 4'd0; #1;
      n_tests++; if (rd1_a !== 16'h0 || b1_a !== 1'b0) begin n_fail++; $display("FAIL zr1_bypass: got %h/%b want 0/0", rd1_a, b1_a); end
      n_tests++; if (rd1_b !== 16'hFFFF || b1_b !== 1'b1) begin n_fail++; $display("FAIL zr0_bypass: got %h/%b want ffff/1", rd1_b, b1_b); end
      tick();
      idle_inputs(); #1;
      n_tests++; if (rd1_a !== 16'h0 || b1_a !== 1'b0) begin n_fail++; $display("FAIL zr1_stored: got %h/%b want 0/0", rd1_a, b1_a); end
      n_tests++; if (rd1_b !== 16'hFFFF || b1_b !== 1'b1) begin n_fail++; $display("FAIL zr0_stored: got %h/%b want ffff/1", rd1_b, b1_b); end
   endtask

   task automatic test_clear();
      for (int i = 1; i < 16; i++) begin
         RegWre = 1'b1; WriteReg = 4'(i); WriteData = 16'h1000 + 16'(i);
         tick();
      end
      RegWre = 1'b0; rs = 4'd9; #1;
      n_tests++; if (rd1_a !== 16'h1009) begin n_fail++; $display("FAIL fill_readback: got %h want 1009", rd1_a); end
      // clear request with a same-cycle write and mark that must still land, then be wiped
      ClearReq = 1'b1; RegWre = 1'b1; WriteReg = 4'd2; WriteData = 16'h7777; MarkWre = 1'b1; MarkReg = 4'd4;
      tick();
      ClearReq = 1'b1; RegWre = 1'b1; WriteReg = 4'd1; WriteData = 16'hABCD; MarkWre = 1'b1; MarkReg = 4'd2;
      rs = 4'd9; rt = 4'd1;
      for (int e = 1; e <= 16; e++) begin
         #1;
         n_tests++; if (rdy_a !== 1'b0 || rd1_a !== 16'h0 || rd2_a !== 16'h0) begin
            n_fail++; $display("FAIL clear_gated step %0d: got rdy=%b %h %h want 0 0 0", e, rdy_a, rd1_a, rd2_a);
         end
         if (e == 16) idle_inputs();
         tick();
      end
      n_tests++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL clear_done_ready: got %b want 1", rdy_a); end
      for (int a = 0; a < 16; a++) begin
         rs = 4'(a); #1;
         n_tests++; if (rd1_a !== 16'h0 || b1_a !== 1'b0) begin n_fail++; $display("FAIL clear_zero R%0d: got %h/%b want 0/0", a, rd1_a, b1_a); end
      end
      // Reset while the clear index is at 8 restarts the full sequence
      ClearReq = 1'b1; tick(); ClearReq = 1'b0;
      for (int e = 0; e < 8; e++) tick();
      Reset = 1'b1; tick(); Reset = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         tick();
         n_tests++; if (rdy_a !== (e == 16)) begin n_fail++; $display("FAIL reset_midclear edge %0d: got %b want %b", e, rdy_a, (e == 16)); end
      end
   endtask

   task automatic test_wide();
      Reset2 = 1'b1; tick(); Reset2 = 1'b0;
      for (int e = 1; e <= 32; e++) begin
         tick();
         if (e == 16 || e >= 31) begin
            n_tests++; if (rdy_c !== (e == 32)) begin n_fail++; $display("FAIL wide_ready edge %0d: got %b want %b", e, rdy_c, (e == 32)); end
         end
      end
      RegWre2 = 1'b1; WriteReg2 = 5'd31; WriteData2 = 32'hDEADBEEF; rs2 = 5'd31; rt2 = 5'd30; #1;
      n_tests++; if (rd1_c !== 32'hDEADBEEF || rd2_c !== 32'h0) begin n_fail++; $display("FAIL wide_bypass: got %h/%h want deadbeef/0", rd1_c, rd2_c); end
      tick();
      RegWre2 = 1'b0; rt2 = 5'd31; #1;
      n_tests++; if (rd2_c !== 32'hDEADBEEF || b2_c !== 1'b0) begin n_fail++; $display("FAIL wide_stored: got %h/%b want deadbeef/0", rd2_c, b2_c); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_scoreboard();
      test_zero_reg();
      test_clear();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
